// File: rtl/uart_rx_bit_timer_pkg.sv
// uart_rx_bit_timer_pkg: shared UART receiver constants (frame phase encoding, minimum prescale)
package uart_rx_bit_timer_pkg;
  typedef enum logic [1:0] {PH_START = 2'd0, PH_DATA = 2'd1, PH_PARITY = 2'd2, PH_STOP = 2'd3} phase_t;
  localparam int MIN_PRESCALE = 4;
endpackage

// File: rtl/uart_rx_bit_timer_if.sv
// uart_rx_bit_timer_if: run/config request from the RX FSM and timing strobes back to the samplers
// master (RX FSM) drives enable, Prescale, PAR_EN, STOP2; slave (bit timer) drives
// edge_cnt, bit_cnt, sample_en, sample_last, bit_end, frame_done, phase.
interface uart_rx_bit_timer_if #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
);
  logic                  enable;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  PAR_EN;
  logic                  STOP2;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  sample_en;
  logic                  sample_last;
  logic                  bit_end;
  logic                  frame_done;
  logic [1:0]            phase;
  modport master (
    output enable, Prescale, PAR_EN, STOP2,
    input  edge_cnt, bit_cnt, sample_en, sample_last, bit_end, frame_done, phase
  );
  modport slave (
    input  enable, Prescale, PAR_EN, STOP2,
    output edge_cnt, bit_cnt, sample_en, sample_last, bit_end, frame_done, phase
  );
endinterface

// File: rtl/uart_rx_bit_timer.sv
// uart_rx_bit_timer: oversampling edge/bit counter with mid-bit sample strobes for the UART receiver
// CLK/RST: clock and async active-high reset; bus: slave side of uart_rx_bit_timer_if
// (config in: enable, Prescale, PAR_EN, STOP2; timing out: counters, strobes, phase).
module uart_rx_bit_timer
  import uart_rx_bit_timer_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = $clog2(DATA_W + 4)
) (
  input logic               CLK,
  input logic               RST,
  uart_rx_bit_timer_if.slave bus
);
  logic [PRESCALE_W-1:0] prescale_q, edge_q, p, mid;
  logic [BIT_CNT_W-1:0]  bit_q, n;
  logic                  par_q, stop2_q, edge_wrap, bit_last, bit_end, frame_done;
  always_comb begin
    p          = prescale_q < PRESCALE_W'(MIN_PRESCALE) ? PRESCALE_W'(MIN_PRESCALE) : prescale_q;
    n          = BIT_CNT_W'(2 + DATA_W) + BIT_CNT_W'(par_q) + BIT_CNT_W'(stop2_q);
    mid        = p >> 1;
    // >= rather than == so an out-of-range count recovers at the next edge
    edge_wrap  = edge_q >= p - PRESCALE_W'(1);
    bit_last   = bit_q == n - BIT_CNT_W'(1);
    bit_end    = bus.enable && edge_q == p - PRESCALE_W'(1);
    frame_done = bit_end && bit_last;
  end
  // Config is captured while idle and at each frame boundary, then frozen for the frame
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prescale_q <= '0;
      par_q      <= 1'b0;
      stop2_q    <= 1'b0;
    end else if (!bus.enable || frame_done) begin
      prescale_q <= bus.Prescale;
      par_q      <= bus.PAR_EN;
      stop2_q    <= bus.STOP2;
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else if (!bus.enable) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_wrap ? '0 : edge_q + PRESCALE_W'(1);
      bit_q  <= bit_q > n - BIT_CNT_W'(1) ? '0 : !edge_wrap ? bit_q : bit_last ? '0 : bit_q + BIT_CNT_W'(1);
    end
  end
  assign bus.edge_cnt    = edge_q;
  assign bus.bit_cnt     = bit_q;
  assign bus.sample_en   = bus.enable && edge_q >= mid - PRESCALE_W'(1) && edge_q <= mid + PRESCALE_W'(1);
  assign bus.sample_last = bus.enable && edge_q == mid + PRESCALE_W'(1);
  assign bus.bit_end     = bit_end;
  assign bus.frame_done  = frame_done;
  assign bus.phase       = !bus.enable || bit_q == '0 ? PH_START :
                           bit_q <= BIT_CNT_W'(DATA_W) ? PH_DATA :
                           bit_q == BIT_CNT_W'(DATA_W + 1) && par_q ? PH_PARITY : PH_STOP;
endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// tb_uart_rx_bit_timer: randomized and directed checks of the bit timer against a frame-time model
module tb_uart_rx_bit_timer;
  import uart_rx_bit_timer_pkg::*;
  localparam int DW = 8;
  localparam int PW = 6;
  localparam int BW = $clog2(DW + 4);
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;
  uart_rx_bit_timer_if #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) bus();
  uart_rx_bit_timer #(.DATA_W(DW), .PRESCALE_W(PW)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  int checks = 0;
  int failures = 0;
  int t = 0;
  int mp = 0;
  int mpar = 0;
  int mst = 0;
  logic [15:0] obs;
  assign obs = {bus.edge_cnt, bus.bit_cnt, bus.sample_en, bus.sample_last, bus.bit_end, bus.frame_done, bus.phase};

  function automatic int m_p();
    return mp < MIN_PRESCALE ? MIN_PRESCALE : mp;
  endfunction

  function automatic int m_n();
    return 2 + DW + mpar + mst;
  endfunction

  function automatic logic [15:0] expv();
    int p = m_p();
    int e = t % p;
    int b = t / p;
    int mid = p / 2;
    logic en = bus.enable;
    logic se = en && e >= mid - 1 && e <= mid + 1;
    logic sl = en && e == mid + 1;
    logic be = en && e == p - 1;
    logic fd = be && b == m_n() - 1;
    logic [1:0] ph = (!en || b == 0) ? 2'd0 : b <= DW ? 2'd1 : (b == DW + 1 && mpar == 1) ? 2'd2 : 2'd3;
    return {PW'(e), BW'(b), se, sl, be, fd, ph};
  endfunction

  task automatic model_edge();
    if (RST) return;
    if (!bus.enable || t >= m_n() * m_p() - 1) begin
      t = 0;
      mp = int'(bus.Prescale);
      mpar = int'(bus.PAR_EN);
      mst = int'(bus.STOP2);
    end else t++;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic e, input int p, input logic pa, input logic s2);
    bus.enable = e;
    bus.Prescale = PW'(p);
    bus.PAR_EN = pa;
    bus.STOP2 = s2;
  endtask

  task automatic test_reset();
    drive(1'b0, 8, 1'b0, 1'b0);
    tick();
    tick();
    #1;
    checks++;
    if (obs !== 16'h0) begin failures++; $display("FAIL reset_state got=%h exp=%h", obs, 16'h0); end
    RST = 1'b0;
    tick();
    tick();
    drive(1'b1, 8, 1'b0, 1'b0);
    for (int i = 0; i <= 43; i++) begin
      if (i > 0) tick();
      #1;
      checks++;
      if (obs !== expv()) begin failures++; $display("FAIL reset_pre i=%0d got=%h exp=%h", i, obs, expv()); end
    end
    #1;
    RST = 1'b1;
    t = 0; mp = 0; mpar = 0; mst = 0;
    #1;
    checks++;
    if (obs !== 16'h0) begin failures++; $display("FAIL reset_async got=%h exp=%h", obs, 16'h0); end
    RST = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      #1;
      checks++;
      if (obs !== expv()) begin failures++; $display("FAIL reset_restart i=%0d got=%h exp=%h", i, obs, expv()); end
    end
  endtask

  task automatic test_basic();
    int fd_first = -1;
    int nfd = 0;
    logic [7:0] se_m = '0;
    logic [7:0] sl_m = '0;
    drive(1'b0, 8, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b1, 8, 1'b0, 1'b0);
    for (int i = 0; i < 240; i++) begin
      if (i > 0) tick();
      #1;
      checks++;
      if (obs !== expv()) begin failures++; $display("FAIL basic i=%0d got=%h exp=%h", i, obs, expv()); end
      if (i < 8) begin se_m[i] = bus.sample_en; sl_m[i] = bus.sample_last; end
      if (bus.frame_done === 1'b1) begin nfd++; if (fd_first < 0) fd_first = i; end
    end
    checks++;
    if (se_m !== 8'b0011_1000) begin failures++; $display("FAIL basic_sample_edges got=%b exp=%b", se_m, 8'b0011_1000); end
    checks++;
    if (sl_m !== 8'b0010_0000) begin failures++; $display("FAIL basic_sample_last got=%b exp=%b", sl_m, 8'b0010_0000); end
    checks++;
    if (fd_first != 79) begin failures++; $display("FAIL basic_frame_done_cycle got=%0d exp=79", fd_first); end
    checks++;
    if (nfd != 3) begin failures++; $display("FAIL basic_back_to_back got=%0d exp=3", nfd); end
  endtask

  task automatic test_par_stop();
    int fd_first = -1;
    logic [1:0] ph [12];
    drive(1'b0, 8, 1'b1, 1'b1);
    tick();
    tick();
    drive(1'b1, 8, 1'b1, 1'b1);
    for (int i = 0; i < 96; i++) begin
      if (i > 0) tick();
      #1;
      checks++;
      if (obs !== expv()) begin failures++; $display("FAIL par_stop i=%0d got=%h exp=%h", i, obs, expv()); end
      if (i % 8 == 0) ph[i / 8] = bus.phase;
      if (bus.frame_done === 1'b1 && fd_first < 0) fd_first = i;
    end
    checks++;
    if (fd_first != 95) begin failures++; $display("FAIL par_stop_frame_done got=%0d exp=95", fd_first); end
    for (int k = 0; k < 12; k++) begin
      logic [1:0] want = k == 0 ? 2'd0 : k <= 8 ? 2'd1 : k == 9 ? 2'd2 : 2'd3;
      checks++;
      if (ph[k] !== want) begin failures++; $display("FAIL par_stop_phase bit=%0d got=%0d exp=%0d", k, ph[k], want); end
    end
  endtask

  task automatic test_cfg_change();
    int fds [2] = '{-1, -1};
    int nfd = 0;
    drive(1'b0, 8, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b1, 8, 1'b0, 1'b0);
    for (int i = 0; i <= 170; i++) begin
      if (i > 0) tick();
      if (i == 20) bus.PAR_EN = 1'b1;
      #1;
      checks++;
      if (obs !== expv()) begin failures++; $display("FAIL cfg_change i=%0d got=%h exp=%h", i, obs, expv()); end
      if (bus.frame_done === 1'b1) begin if (nfd < 2) fds[nfd] = i; nfd++; end
    end
    checks++;
    if (fds[0] != 79) begin failures++; $display("FAIL cfg_change_first got=%0d exp=79", fds[0]); end
    checks++;
    if (fds[1] != 167) begin failures++; $display("FAIL cfg_change_second got=%0d exp=167", fds[1]); end
  endtask

  task automatic test_clamp();
    logic [3:0] se4 = '0;
    logic [7:0] be8 = '0;
    logic [4:0] se5 = '0;
    logic [9:0] be10 = '0;
    drive(1'b0, 2, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b1, 2, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      #1;
      checks++;
      if (obs !== expv()) begin failures++; $display("FAIL clamp2 i=%0d got=%h exp=%h", i, obs, expv()); end
      if (i < 4) se4[i] = bus.sample_en;
      be8[i] = bus.bit_end;
    end
    checks++;
    if (se4 !== 4'b1110) begin failures++; $display("FAIL clamp2_samples got=%b exp=%b", se4, 4'b1110); end
    checks++;
    if (be8 !== 8'b1000_1000) begin failures++; $display("FAIL clamp2_bit_end got=%b exp=%b", be8, 8'b1000_1000); end
    drive(1'b0, 5, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b1, 5, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      #1;
      checks++;
      if (obs !== expv()) begin failures++; $display("FAIL p5 i=%0d got=%h exp=%h", i, obs, expv()); end
      if (i < 5) se5[i] = bus.sample_en;
      be10[i] = bus.bit_end;
    end
    checks++;
    if (se5 !== 5'b01110) begin failures++; $display("FAIL p5_samples got=%b exp=%b", se5, 5'b01110); end
    checks++;
    if (be10 !== 10'b10_0001_0000) begin failures++; $display("FAIL p5_bit_end got=%b exp=%b", be10, 10'b10_0001_0000); end
  endtask

  task automatic test_abort();
    int nfd = 0;
    drive(1'b0, 8, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b1, 8, 1'b0, 1'b0);
    for (int i = 0; i <= 35; i++) begin
      if (i > 0) tick();
      #1;
      checks++;
      if (obs !== expv()) begin failures++; $display("FAIL abort_run i=%0d got=%h exp=%h", i, obs, expv()); end
      if (bus.frame_done === 1'b1) nfd++;
    end
    bus.enable = 1'b0;
    #1;
    checks++;
    if (obs !== {PW'(3), BW'(4), 6'b0}) begin failures++; $display("FAIL abort_strobes_off got=%h exp=%h", obs, {PW'(3), BW'(4), 6'b0}); end
    tick();
    #1;
    checks++;
    if ({bus.edge_cnt, bus.bit_cnt} !== '0) begin failures++; $display("FAIL abort_cleared got=%h exp=0", {bus.edge_cnt, bus.bit_cnt}); end
    bus.enable = 1'b1;
    #1;
    checks++;
    if (obs !== 16'h0) begin failures++; $display("FAIL abort_restart got=%h exp=%h", obs, 16'h0); end
    for (int i = 1; i <= 100; i++) begin
      tick();
      #1;
      checks++;
      if (obs !== expv()) begin failures++; $display("FAIL abort_rerun i=%0d got=%h exp=%h", i, obs, expv()); end
      if (i < 79 && bus.frame_done === 1'b1) nfd++;
    end
    checks++;
    if (nfd != 0) begin failures++; $display("FAIL abort_no_frame_done got=%0d exp=0", nfd); end
  endtask

  task automatic test_random();
    drive(1'b0, 8, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 600; i++) begin
      tick();
      if ($urandom_range(0, 39) == 0) bus.enable = ~bus.enable;
      if ($urandom_range(0, 9) == 0) begin
        bus.Prescale = PW'($urandom_range(0, 12));
        bus.PAR_EN = 1'($urandom_range(0, 1));
        bus.STOP2 = 1'($urandom_range(0, 1));
      end
      #1;
      checks++;
      if (obs !== expv()) begin failures++; $display("FAIL random i=%0d got=%h exp=%h", i, obs, expv()); end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 8, 1'b0, 1'b0);
    test_reset();
    test_basic();
    test_par_stop();
    test_cfg_change();
    test_clamp();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_bit_timer.md
# uart_rx_bit_timer

Parametrised bit-timing engine for the UART receiver. It counts oversampling edges within each bit and bits within each frame for a configurable data width, optional parity and one or two stop bits. It emits mid-bit sample strobes, a bit-end pulse, a frame-done pulse and the current frame phase. It sits between the RX FSM and the data/parity/stop samplers, and is the generalised successor of the fixed 8-bit edge/bit counter.

## Interface
- DATA_W, default 8: data bits per frame; legal range 5..9.
- PRESCALE_W, default 6: width of the Prescale input.
- BIT_CNT_W, default $clog2(DATA_W+4): derived width of the bit counter; not to be overridden.
- CLK  in  1  system clock; all state updates on its rising edge.
- RST  in  1  reset, asynchronous, active-high; clears all state.
- enable  in  1  run request from the RX FSM; low = idle and clear.
- Prescale  in  PRESCALE_W  oversampling edges per bit.
- PAR_EN  in  1  parity bit present in the frame.
- STOP2  in  1  two stop bits instead of one.
- edge_cnt  out  PRESCALE_W  edge index within the current bit, 0..P-1.
- bit_cnt  out  BIT_CNT_W  bit index within the frame, 0..N-1.
- sample_en  out  1  high on the three mid-bit sample edges.
- sample_last  out  1  high on the third sample edge; majority decision point.
- bit_end  out  1  high on the last edge of every bit.
- frame_done  out  1  high on the last edge of the last bit of the frame.
- phase  out  2  0 START/idle, 1 DATA, 2 PARITY, 3 STOP.

## Operation
- Configuration registers prescale_q, par_q and stop2_q load from their inputs every cycle while enable=0, and again at each edge where frame_done=1. They are held constant for the rest of the frame.
- P = max(prescale_q, 4). Values 0..3 are clamped to 4.
- N = 2 + DATA_W + par_q + stop2_q (start + data + parity + stop bits).
- mid = P>>1. Sample edges are at edge_cnt = mid-1, mid and mid+1.
- While enable=1, at each edge:
  - If edge_cnt < P-1, edge_cnt increments.
  - Otherwise edge_cnt returns to 0 and bit_cnt increments, or wraps to 0 when bit_cnt = N-1.
  - Wrap-around starts the next frame with no idle gap.
- enable=0: at the next edge, edge_cnt and bit_cnt become 0. All strobes are held low regardless of the counters.
- Strobe and phase decode, each term qualified by enable=1:
  - sample_en: edge_cnt is one of the three sample edges.
  - sample_last: edge_cnt = mid+1.
  - bit_end: edge_cnt = P-1.
  - frame_done: bit_end and bit_cnt = N-1.
  - phase:
    - 0 when bit_cnt = 0.
    - 1 when bit_cnt is 1..DATA_W.
    - 2 when bit_cnt = DATA_W+1 and par_q = 1.
    - 3 for all remaining bits.
- Mid-frame changes on Prescale, PAR_EN or STOP2 have no effect until the next frame boundary or the next idle period.
- Disabling mid-frame aborts the frame silently; frame_done does not pulse.
- If edge_cnt or bit_cnt is ever out of range, it wraps to 0 at the next edge. No lock-up is permitted.

## Timing
- Reset values: edge_cnt=0, bit_cnt=0, configuration registers = 0, and therefore all strobes = 0 and phase = 0.
- Reset takes effect asynchronously, mid-frame included.
- Counters are registered. Strobes and phase are combinational decodes of registered state plus enable. There is no other input-to-output combinational path.
- The first enabled cycle shows edge_cnt=0. A bit lasts exactly P cycles and a frame exactly N×P cycles.
- Prescale, PAR_EN and STOP2 must be stable for at least one cycle before enable rises.
- When frame_done and an enable fall coincide, frame_done pulses in that cycle and the counters clear at the next edge.

## Structure
- Shared uart package holds:
  - phase encoding constants PH_START, PH_DATA, PH_PARITY and PH_STOP;
  - the minimum prescale constant, 4.
- No sub-module. The design is a single block: configuration latch, two counters and the decode logic.

## Test plan
- Reset: assert RST at bit_cnt=5, edge_cnt=3 → all outputs are 0 before the next CLK edge. Release RST with enable=1 → counting restarts from 0/0.
- DATA_W=8, P=8, PAR_EN=0, STOP2=0:
  - sample_en at edge_cnt 3, 4, 5; sample_last at 5;
  - bit_end every 8 cycles;
  - frame_done in cycle 79 after enable rises; bit_cnt 9→0; back-to-back frames.
- PAR_EN=1, STOP2=1, P=8 → N=12, frame_done in cycle 95. Phase sequence is 0, 1×8, 2, 3, 3.
- Toggle PAR_EN 0→1 at cycle 20 of a P=8 frame → that frame stays at 10 bits; the next frame is 11 bits.
- Prescale=2 → P clamped to 4, samples at edge_cnt 1, 2, 3. Prescale=5 → samples at 1, 2, 3 and bit_end at 4.
- Drop enable at bit_cnt=4 → no frame_done; counters are 0 the next cycle. Re-enable → a fresh frame starts with phase=0.
